instr_queue: RTL and testbench



---
 rtl/instr_queue_pkg.sv | 13 +
 rtl/instr_queue_fifo.sv | 68 ++++++
 rtl/instr_queue.sv | 63 ++++++
 tb/tb_instr_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared constants for the decoded-instruction queue between DECODER and execute.
package instr_queue_pkg;

    localparam int INSTR_W   = 32;
    localparam int ADR_W     = 20;
    localparam int FADR_W    = 21;
    localparam int DEPTH_DEF = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_queue_fifo.sv
// Instruction storage ring: entries, read/write pointers and occupancy.
import instr_queue_pkg::*;

module instr_queue_fifo #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = INSTR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clr,
    input  logic [IW-1:0]           din,
    output logic [IW-1:0]           dout,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic [cnt_w(DEPTH)-1:0] count_nxt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_nxt = count_q + CW'(push) - CW'(pop);
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_nxt;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        // Clear wins; stale entry contents are harmless once count is 0.
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_queue.sv
// Pulls decoded instructions from DECODER over reqi/acki and issues them
// to execute with valid/ready; sigflush drops everything buffered.
import instr_queue_pkg::*;

module instr_queue #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW    = INSTR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      reqi,
    input  logic                      acki,
    input  logic [IW-1:0]             instr,
    input  logic                      sigflush,
    output logic                      issue_valid,
    output logic [IW-1:0]             issue_instr,
    input  logic                      issue_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          reqi_q, reqi_d;
    logic          push, pop;
    logic [CW-1:0] fifo_count, count_nxt;

    assign push        = reqi_q && acki;
    assign pop         = issue_valid && issue_ready;
    assign issue_valid = (fifo_count != '0);
    assign count       = fifo_count;
    assign reqi        = reqi_q;

    // Request only when the next occupancy still has room, so a push
    // can never land on a full queue.
    always_comb begin
        reqi_d = (count_nxt < FULL) && !sigflush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reqi_q <= 1'b0;
        end else begin
            reqi_q <= reqi_d;
        end
    end

    instr_queue_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clr       (sigflush),
        .din       (instr),
        .dout      (issue_instr),
        .count     (fifo_count),
        .count_nxt (count_nxt)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: stimulus pushes expected issues into a
// scoreboard; a negedge monitor pops and compares every accepted issue.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int IW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reqi;
    logic          acki;
    logic [IW-1:0] instr;
    logic          sigflush;
    logic          issue_valid;
    logic [IW-1:0] issue_instr;
    logic          issue_ready;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] sb [$];

    instr_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqi        (reqi),
        .acki        (acki),
        .instr       (instr),
        .sigflush    (sigflush),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_ready (issue_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic state(input string name, input int c, input bit rq,
                         input bit vld);
        chk({name, "_count"}, 32'(count), 32'(c));
        chk({name, "_reqi"}, 32'(reqi), 32'(rq));
        chk({name, "_valid"}, 32'(issue_valid), 32'(vld));
    endtask

    task automatic feed(input logic [IW-1:0] v);
        acki  = 1'b1;
        instr = v;
        sb.push_back(v);
        tick();
        acki  = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && !sigflush && issue_valid && issue_ready) begin
                if (sb.size() == 0) begin
                    chk("issue_unexpected", issue_instr, 32'h0);
                end else begin
                    chk("issue_order", issue_instr, sb.pop_front());
                end
            end
        end
    end

    initial begin : stim
        rst_n       = 1'b0;
        acki        = 1'b0;
        instr       = '0;
        sigflush    = 1'b0;
        issue_ready = 1'b0;

        // 1. reset, then fill to full
        tick();
        tick();
        state("reset", 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("reqi_after_rel", 32'(reqi), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            acki  = 1'b1;
            instr = 32'h1111_0000 + 32'(i);
            sb.push_back(instr);
            tick();
        end
        acki = 1'b0;
        state("full", 4, 1'b0, 1'b1);
        chk("full_head", issue_instr, 32'h1111_0001);

        // 5. stray ack while reqi=0
        acki  = 1'b1;
        instr = 32'hDEAD_BEEF;
        tick();
        acki  = 1'b0;
        state("stray", 4, 1'b0, 1'b1);

        // 2. drain while full
        issue_ready = 1'b1;
        tick();
        state("first_pop", 3, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        state("drained", 0, 1'b1, 1'b0);
        chk("sb_drain1", 32'(sb.size()), 32'd0);

        // 3. simultaneous push/pop at count=1
        issue_ready = 1'b0;
        feed(32'h2222_0000);
        chk("pp_pre", 32'(count), 32'd1);
        issue_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            acki  = 1'b1;
            instr = 32'h2222_0000 + 32'(i);
            sb.push_back(instr);
            tick();
            chk("pp_count", 32'(count), 32'd1);
        end
        acki = 1'b0;
        tick();
        chk("pp_end", 32'(count), 32'd0);
        chk("sb_drain2", 32'(sb.size()), 32'd0);

        // 4. flush with count=3 and an ack in the flush cycle
        issue_ready = 1'b0;
        feed(32'h3333_0001);
        feed(32'h3333_0002);
        feed(32'h3333_0003);
        state("pre_flush", 3, 1'b1, 1'b1);
        sigflush = 1'b1;
        acki     = 1'b1;
        instr    = 32'h3333_DEAD;
        tick();
        sb.delete();
        sigflush = 1'b0;
        acki     = 1'b0;
        state("flushed", 0, 1'b0, 1'b0);
        tick();
        chk("reqi_post_flush", 32'(reqi), 32'd1);
        feed(32'h4444_0001);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("sb_drain3", 32'(sb.size()), 32'd0);

        // 6. reset mid-operation
        feed(32'h5555_0001);
        feed(32'h5555_0002);
        state("pre_rst", 2, 1'b1, 1'b1);
        rst_n = 1'b0;
        acki  = 1'b1;
        instr = 32'h5555_DEAD;
        tick();
        sb.delete();
        rst_n = 1'b1;
        acki  = 1'b0;
        state("mid_rst", 0, 1'b0, 1'b0);
        tick();
        chk("reqi_post_rst", 32'(reqi), 32'd1);
        feed(32'h6666_0001);
        feed(32'h6666_0002);
        chk("refill", 32'(count), 32'd2);
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;
        state("final", 0, 1'b1, 1'b0);
        chk("sb_drain4", 32'(sb.size()), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
